// File: rtl/drive_sequencer.sv
// Frame-paced supervisor feeding speed/reverse/centroid to the PID drive.
// Optional frame watchdog (FAULT state) enabled by DRIVE_SEQ_WDOG_EN.
module drive_sequencer #(
  parameter logic [15:0] TARGET        = 16'd159,
  parameter logic [7:0]  RAMP_STEP     = 8'd4,
  parameter logic [7:0]  MAX_SPEED     = 8'd100,
  parameter logic [7:0]  SEARCH_SPEED  = 8'd20,
  parameter logic [3:0]  LOST_FRAMES   = 4'd3,
  parameter logic [7:0]  SEARCH_FRAMES = 8'd30
`ifdef DRIVE_SEQ_WDOG_EN
  ,
  parameter logic [31:0] WDOG_CYCLES   = 32'd5000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_done,
  input  logic        centroid_valid,
  input  logic [15:0] centroid_in,
  input  logic [7:0]  target_speed,
  output logic [7:0]  speed,
  output logic        reverse,
  output logic [15:0] centroid_out,
  output logic [2:0]  state,
  output logic        line_lost
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_TRACK  = 3'd2,
    S_LOST   = 3'd3,
    S_SEARCH = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_speed, w_speed_nxt;
  logic        r_rev, w_rev_nxt;
  logic [15:0] r_cen, w_cen_nxt;
  logic        r_lost, w_lost_nxt;
  logic [3:0]  r_miss, w_miss_nxt;
  logic [7:0]  r_srch, w_srch_nxt;

  logic [7:0]  w_tgt;
  logic [8:0]  w_sum;
  logic [7:0]  w_ramp;
  logic [3:0]  w_miss_inc;
  logic [7:0]  w_srch_inc;
  logic        w_lost_hit;

  assign w_tgt      = (target_speed > MAX_SPEED) ? MAX_SPEED : target_speed;
  assign w_sum      = {1'b0, r_speed} + {1'b0, RAMP_STEP};
  assign w_ramp     = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[7:0];
  assign w_miss_inc = (r_miss == 4'hF) ? r_miss : r_miss + 4'd1;
  assign w_srch_inc = (r_srch == 8'hFF) ? r_srch : r_srch + 8'd1;
  assign w_lost_hit = frame_done && !centroid_valid &&
                      (w_miss_inc >= LOST_FRAMES);

`ifdef DRIVE_SEQ_WDOG_EN
  logic [31:0] r_wdog;
  logic        w_wdog_trip;

  assign w_wdog_trip = (r_wdog >= WDOG_CYCLES) &&
                       (r_state inside {S_RAMP, S_TRACK, S_LOST, S_SEARCH});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_speed <= 8'd0;
      r_rev   <= 1'b0;
      r_cen   <= TARGET;
      r_lost  <= 1'b0;
      r_miss  <= 4'd0;
      r_srch  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
      r_rev   <= w_rev_nxt;
      r_cen   <= w_cen_nxt;
      r_lost  <= w_lost_nxt;
      r_miss  <= w_miss_nxt;
      r_srch  <= w_srch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_RAMP;
      S_RAMP: begin
        if (frame_done) begin
          if (w_lost_hit)          w_state_nxt = S_LOST;
          else if (w_ramp == w_tgt) w_state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (frame_done) begin
          if (w_lost_hit)           w_state_nxt = S_LOST;
          else if (w_tgt > r_speed) w_state_nxt = S_RAMP;
        end
      end
      S_LOST: begin
        if (frame_done) begin
          if (centroid_valid)
            w_state_nxt = S_RAMP;
          else if (w_srch_inc >= SEARCH_FRAMES)
            w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (frame_done && centroid_valid)
          w_state_nxt = S_RAMP;
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef DRIVE_SEQ_WDOG_EN
    if (w_wdog_trip) w_state_nxt = S_FAULT;
`endif
    if (!enable) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_speed_nxt = r_speed;
    w_cen_nxt   = r_cen;
    w_miss_nxt  = r_miss;
    w_srch_nxt  = r_srch;
    unique case (r_state)
      S_RAMP, S_TRACK: begin
        if (frame_done) begin
          if (centroid_valid) begin
            w_cen_nxt  = centroid_in;
            w_miss_nxt = 4'd0;
          end else begin
            w_miss_nxt = w_miss_inc;
          end
          if (r_state == S_RAMP)  w_speed_nxt = w_ramp;
          else if (w_tgt < r_speed) w_speed_nxt = w_tgt;
        end
      end
      S_LOST, S_SEARCH: begin
        if (frame_done) begin
          if (centroid_valid) begin
            w_cen_nxt  = centroid_in;
            w_miss_nxt = 4'd0;
            w_srch_nxt = 8'd0;
          end else if (r_state == S_LOST) begin
            w_srch_nxt = w_srch_inc;
          end
        end
      end
      default: begin
        w_speed_nxt = r_speed;
      end
    endcase
    // Ramping out of LOST/SEARCH resumes from the held search speed.
    if (w_state_nxt == S_LOST || w_state_nxt == S_SEARCH)
      w_speed_nxt = SEARCH_SPEED;
    if (w_state_nxt == S_IDLE || w_state_nxt == S_FAULT) begin
      w_speed_nxt = 8'd0;
      w_cen_nxt   = TARGET;
      w_miss_nxt  = 4'd0;
      w_srch_nxt  = 8'd0;
    end
    w_rev_nxt  = (w_state_nxt == S_SEARCH);
    w_lost_nxt = (w_state_nxt == S_LOST) || (w_state_nxt == S_SEARCH);
  end

`ifdef DRIVE_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wdog <= 32'd0;
    else if (frame_door_clear(w_state_nxt))
      r_wdog <= 32'd0;
    else if (r_wdog != 32'hFFFF_FFFF)
      r_wdog <= r_wdog + 32'd1;
  end

  function automatic logic frame_door_clear(input state_e nxt);
    return frame_done || !(nxt inside {S_RAMP, S_TRACK, S_LOST, S_SEARCH});
  endfunction
`endif

  assign speed        = r_speed;
  assign reverse      = r_rev;
  assign centroid_out = r_cen;
  assign state        = r_state;
  assign line_lost    = r_lost;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: ramp, track, lost/search,
// clamping, enable priority, async reset and optional watchdog.
module tb_drive_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame_done;
  logic        centroid_valid;
  logic [15:0] centroid_in;
  logic [7:0]  target_speed;
  logic [7:0]  speed;
  logic        reverse;
  logic [15:0] centroid_out;
  logic [2:0]  state;
  logic        line_lost;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef DRIVE_SEQ_WDOG_EN
  drive_sequencer #(.WDOG_CYCLES(32'd1000)) u_dut (
`else
  drive_sequencer u_dut (
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .frame_done     (frame_done),
    .centroid_valid (centroid_valid),
    .centroid_in    (centroid_in),
    .target_speed   (target_speed),
    .speed          (speed),
    .reverse        (reverse),
    .centroid_out   (centroid_out),
    .state          (state),
    .line_lost      (line_lost)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame(input logic v, input logic [15:0] c);
    @(negedge clk);
    frame_done     = 1'b1;
    centroid_valid = v;
    centroid_in    = c;
    @(negedge clk);
    frame_done     = 1'b0;
    centroid_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st,
                         input logic [7:0] sp, input logic rv,
                         input logic [15:0] cn, input logic ll);
    chk({tag, ".state"}, state, st);
    chk({tag, ".speed"}, speed, sp);
    chk({tag, ".reverse"}, reverse, rv);
    chk({tag, ".centroid"}, centroid_out, cn);
    chk({tag, ".line_lost"}, line_lost, ll);
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    frame_done     = 1'b0;
    centroid_valid = 1'b0;
    centroid_in    = 16'd0;
    target_speed   = 8'd0;
    #12;
    chk_out("reset", 3'd0, 8'd0, 1'b0, 16'd159, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // start-up ramp to 20
    enable       = 1'b1;
    target_speed = 8'd20;
    @(negedge clk);
    chk_out("enter_ramp", 3'd1, 8'd0, 1'b0, 16'd159, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      frame(1'b1, 16'd159);
      chk("ramp20.speed", speed, 32'(4 * i));
    end
    chk("ramp20.track", state, 3'd2);
    chk("ramp20.rev", reverse, 1'b0);

    // line loss
    frame(1'b1, 16'd200);
    chk("track.cen200", centroid_out, 16'd200);
    for (int i = 1; i <= 3; i++) begin
      frame(1'b0, 16'd999);
      chk("miss.cen_hold", centroid_out, 16'd200);
      if (i < 3) chk("miss.still_track", state, 3'd2);
    end
    chk_out("lost", 3'd3, 8'd20, 1'b0, 16'd200, 1'b1);

    for (int i = 1; i <= 30; i++) begin
      frame(1'b0, 16'd0);
      if (i == 29) chk("lost29.state", state, 3'd3);
    end
    chk_out("search", 3'd4, 8'd20, 1'b1, 16'd200, 1'b1);

    // reacquire and ramp from search speed
    target_speed = 8'd40;
    frame(1'b1, 16'd120);
    chk_out("reacq", 3'd1, 8'd20, 1'b0, 16'd120, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      frame(1'b1, 16'd120);
      chk("ramp40.speed", speed, 32'(20 + 4 * i));
    end
    chk("ramp40.track", state, 3'd2);

    // clamp at MAX_SPEED
    target_speed = 8'd150;
    frame(1'b1, 16'd130);
    chk("clamp.to_ramp", state, 3'd1);
    chk("clamp.hold40", speed, 8'd40);
    for (int i = 1; i <= 15; i++) frame(1'b1, 16'd130);
    chk("clamp.speed100", speed, 8'd100);
    chk("clamp.track", state, 3'd2);

    // speed drop in TRACK
    target_speed = 8'd40;
    frame(1'b1, 16'd130);
    chk("drop.speed40", speed, 8'd40);
    chk("drop.track", state, 3'd2);

    // enable falls together with a frame in SEARCH
    for (int i = 0; i < 33; i++) frame(1'b0, 16'd0);
    chk("search2.state", state, 3'd4);
    @(negedge clk);
    enable         = 1'b0;
    frame_done     = 1'b1;
    centroid_valid = 1'b1;
    centroid_in    = 16'd77;
    @(negedge clk);
    frame_done     = 1'b0;
    centroid_valid = 1'b0;
    chk_out("en_drop", 3'd0, 8'd0, 1'b0, 16'd159, 1'b0);

    // target_speed 0 in RAMP
    target_speed = 8'd0;
    enable       = 1'b1;
    @(negedge clk);
    chk("tgt0.ramp", state, 3'd1);
    frame(1'b1, 16'd50);
    chk_out("tgt0", 3'd2, 8'd0, 1'b0, 16'd50, 1'b0);

    // asynchronous reset mid-RAMP
    target_speed = 8'd60;
    frame(1'b1, 16'd300);
    chk("pre_rst.ramp", state, 3'd1);
    frame(1'b1, 16'd300);
    chk("pre_rst.speed", speed, 8'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 3'd0, 8'd0, 1'b0, 16'd159, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    target_speed = 8'd20;
    @(negedge clk);
    for (int i = 0; i < 5; i++) frame(1'b1, 16'd159);
    chk("rerun.track", state, 3'd2);

    // miss counter clears on a valid frame
    frame(1'b0, 16'd0);
    frame(1'b0, 16'd0);
    frame(1'b1, 16'd91);
    frame(1'b0, 16'd0);
    frame(1'b0, 16'd0);
    chk("miss_clear.track", state, 3'd2);
    frame(1'b0, 16'd0);
    chk("miss_clear.lost", state, 3'd3);

    // valid frame in LOST resumes ramp from search speed
    frame(1'b1, 16'd90);
    chk("lost_reacq.state", state, 3'd1);
    chk("lost_reacq.speed", speed, 8'd20);
    chk("lost_reacq.ll", line_lost, 1'b0);
    frame(1'b1, 16'd90);
    chk("lost_reacq.track", state, 3'd2);

`ifdef DRIVE_SEQ_WDOG_EN
    begin
      int cyc;
      cyc = 0;
      while (state != 3'd5 && cyc < 1100) begin
        @(negedge clk);
        cyc++;
      end
      chk("wdog.fault", state, 3'd5);
      chk("wdog.window", 32'(cyc >= 995 && cyc <= 1005), 1);
      chk("wdog.speed", speed, 8'd0);
      chk("wdog.cen", centroid_out, 16'd159);
      enable = 1'b0;
      @(negedge clk);
      chk("wdog.idle", state, 3'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
